// File: rtl/keccak_sequencer.sv
// keccak_sequencer
//   Packs an incoming message byte stream into 32-bit words for a Keccak
//   hash core. It signals the final, partially filled word, then streams
//   the digest back out one byte at a time.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   s_data/s_valid/
//   s_last/s_ready       message byte stream in (s_last marks the final byte)
//   m_data/m_valid/
//   m_last/m_ready       digest byte stream out
//   core_reset           held high for CLR_CYCLES at message start
//   core_in/core_in_ready/
//   core_is_last/
//   core_byte_num        word handed to the core, with the final-word info
//   core_buffer_full     core cannot take a word this cycle
//   core_out/
//   core_out_ready       digest from the core, and digest-valid
//   busy                 high whenever not idle
//
// Configuration
//   KECCAK_SEQ_TRUNC256_EN  when defined, only the first 32 digest bytes
//                           (core_out[511:256]) are emitted; otherwise 64.
module keccak_sequencer #(
    parameter int CLR_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    input  logic         s_last,
    output logic         s_ready,
    output logic [7:0]   m_data,
    output logic         m_valid,
    output logic         m_last,
    input  logic         m_ready,
    output logic         core_reset,
    output logic [31:0]  core_in,
    output logic         core_in_ready,
    output logic         core_is_last,
    output logic [1:0]   core_byte_num,
    input  logic         core_buffer_full,
    input  logic [511:0] core_out,
    input  logic         core_out_ready,
    output logic         busy
);

`ifdef KECCAK_SEQ_TRUNC256_EN
    localparam logic [5:0] LAST_IDX = 6'd31;
`else
    localparam logic [5:0] LAST_IDX = 6'd63;
`endif
    localparam logic [3:0] CLR_LAST = 4'(CLR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, CLR, FILL, PUSH, PUSH_LAST, WAIT, SEND
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  clr_cnt_q, clr_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  byte_num_q, byte_num_d;
    logic        pend_last_q, pend_last_d;   // full word was the last one: zero word still owed
    logic [5:0]  idx_q, idx_d;
    logic [8:0]  sel_hi;

    // State register. Only control state is reset; the word and the
    // byte-number registers are always written before they are used.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            clr_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            pend_last_q <= 1'b0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            pend_last_q <= pend_last_d;
            idx_q       <= idx_d;
        end
        word_q     <= word_d;
        byte_num_q <= byte_num_d;
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        byte_num_d  = byte_num_q;
        pend_last_d = pend_last_q;
        idx_d       = idx_q;
        case (state_q)
            IDLE: begin
                // The waiting byte is left on the bus and taken in FILL.
                if (s_valid) begin
                    state_d   = CLR;
                    clr_cnt_d = '0;
                end
            end
            CLR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d     = FILL;
                    byte_cnt_d  = '0;
                    word_d      = '0;
                    pend_last_d = 1'b0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 4'd1;
                end
            end
            FILL: begin
                if (s_valid) begin
                    // First byte of a word lands in the most significant lane.
                    case (byte_cnt_q)
                        2'd0:    word_d[31:24] = s_data;
                        2'd1:    word_d[23:16] = s_data;
                        2'd2:    word_d[15:8]  = s_data;
                        default: word_d[7:0]   = s_data;
                    endcase
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (s_last) begin
                        if (byte_cnt_q == 2'd3) begin
                            state_d     = PUSH;
                            pend_last_d = 1'b1;
                        end else begin
                            state_d    = PUSH_LAST;
                            byte_num_d = byte_cnt_q + 2'd1;
                        end
                    end else if (byte_cnt_q == 2'd3) begin
                        state_d = PUSH;
                    end
                end
            end
            PUSH: begin
                if (!core_buffer_full) begin
                    word_d     = '0;
                    byte_cnt_d = '0;
                    if (pend_last_q) begin
                        state_d     = PUSH_LAST;
                        byte_num_d  = 2'd0;
                        pend_last_d = 1'b0;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            PUSH_LAST: begin
                if (!core_buffer_full) state_d = WAIT;
            end
            WAIT: begin
                if (core_out_ready) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (m_ready) begin
                    if (idx_q == LAST_IDX) state_d = IDLE;
                    else                   idx_d   = idx_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs. While reset is asserted, outputs are forced to their idle values
    // even before the synchronous reset has taken effect on the state.
    always_comb begin
        s_ready       = 1'b0;
        m_data        = '0;
        m_valid       = 1'b0;
        m_last        = 1'b0;
        core_reset    = 1'b0;
        core_in       = '0;
        core_in_ready = 1'b0;
        core_is_last  = 1'b0;
        core_byte_num = '0;
        busy          = 1'b0;
        sel_hi        = 9'd511 - {idx_q, 3'b000};
        if (reset) begin
            core_reset = 1'b1;
        end else begin
            busy = (state_q != IDLE);
            case (state_q)
                CLR:  core_reset = 1'b1;
                FILL: s_ready    = 1'b1;
                PUSH: begin
                    core_in_ready = 1'b1;
                    core_in       = word_q;
                end
                PUSH_LAST: begin
                    core_in_ready = 1'b1;
                    core_in       = word_q;
                    core_is_last  = 1'b1;
                    core_byte_num = byte_num_q;
                end
                SEND: begin
                    m_valid = 1'b1;
                    m_data  = core_out[sel_hi -: 8];
                    m_last  = (idx_q == LAST_IDX);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_sequencer.sv
module tb_keccak_sequencer;

    localparam int CLR_CYCLES = 2;
`ifdef KECCAK_SEQ_TRUNC256_EN
    localparam int NB = 32;
`else
    localparam int NB = 64;
`endif

    logic         clk;
    logic         reset;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic [7:0]   m_data;
    logic         m_valid;
    logic         m_last;
    logic         m_ready;
    logic         core_reset;
    logic [31:0]  core_in;
    logic         core_in_ready;
    logic         core_is_last;
    logic [1:0]   core_byte_num;
    logic         core_buffer_full;
    logic [511:0] core_out;
    logic         core_out_ready;
    logic         busy;

    keccak_sequencer #(.CLR_CYCLES(CLR_CYCLES)) dut (
        .clk              (clk),
        .reset            (reset),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .s_last           (s_last),
        .s_ready          (s_ready),
        .m_data           (m_data),
        .m_valid          (m_valid),
        .m_last           (m_last),
        .m_ready          (m_ready),
        .core_reset       (core_reset),
        .core_in          (core_in),
        .core_in_ready    (core_in_ready),
        .core_is_last     (core_is_last),
        .core_byte_num    (core_byte_num),
        .core_buffer_full (core_buffer_full),
        .core_out         (core_out),
        .core_out_ready   (core_out_ready),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Message under test and scenario knobs
    logic [7:0]  msg [0:63];
    int          msg_len;
    bit          hold_mode, toggle_mode, fixed_dig, abort_mode;
    int          full_pct;

    // Core words: {word, is_last, byte_num}
    logic [34:0] exp_q[$];
    logic [34:0] got_q[$];

    // Reference: bytes are packed big-endian four to a word; the remainder
    // (possibly empty) forms the final word, flagged last with its byte count.
    task automatic build_expected();
        int nfull;
        int rem;
        logic [31:0] w;
        exp_q.delete();
        nfull = msg_len / 4;
        rem   = msg_len % 4;
        for (int i = 0; i < nfull; i++) begin
            w = {msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]};
            exp_q.push_back({w, 1'b0, 2'd0});
        end
        w = '0;
        for (int j = 0; j < rem; j++) w[31-8*j -: 8] = msg[4*nfull+j];
        exp_q.push_back({w, 1'b1, 2'(rem)});
    endtask

    task automatic set_modes(input bit h, input bit t, input bit f, input bit a, input int pct);
        hold_mode   = h;
        toggle_mode = t;
        fixed_dig   = f;
        abort_mode  = a;
        full_pct    = pct;
    endtask

    task automatic idle_cycles(input int n);
        s_valid          = 1'b0;
        s_last           = 1'b0;
        core_buffer_full = 1'b0;
        core_out_ready   = 1'b0;
        m_ready          = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_message(input string name);
        int pos = 0;
        int cyc = 0;
        int crst = 0;
        int rx = 0;
        int dly = -1;
        int hold_st = 0;
        int hold_cnt = 0;
        int junk_bad = 0;
        logic [31:0] hold_word = '0;
        logic [7:0] dig [0:63];
        bit done = 1'b0;
        bit aborted = 1'b0;

        build_expected();
        got_q.delete();
        hold_st = hold_mode ? 1 : 0;
        for (int i = 0; i < 64; i++) dig[i] = fixed_dig ? 8'(i) : 8'($urandom);

        while (!done && cyc < 3000) begin
            // drive inputs for this cycle
            if (pos < msg_len) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_data  = msg[pos];
                s_last  = (pos == msg_len - 1);
            end else begin
                s_valid = 1'b1;
                s_data  = 8'hEE;
                s_last  = 1'($urandom);
            end
            if (hold_st == 1)      core_buffer_full = 1'b1;
            else if (hold_st == 2) core_buffer_full = (hold_cnt < 10);
            else                   core_buffer_full = ($urandom_range(0, 99) < full_pct);
            m_ready = toggle_mode ? ~m_ready : 1'($urandom);
            if (dly == 0) begin
                for (int i = 0; i < 64; i++) core_out[511-8*i -: 8] = dig[i];
                core_out_ready = 1'b1;
                dly = -1;
            end else begin
                core_out_ready = 1'b0;
                if (dly > 0) dly--;
            end
            if (abort_mode && !aborted && rx == 5) begin
                reset   = 1'b1;
                m_ready = 1'b0;
                aborted = 1'b1;
            end

            // observe, away from the clock edge
            #2;
            if (reset) begin
                check({name, "_rst_mvalid"}, 64'(m_valid), 64'd0);
                check({name, "_rst_core_reset"}, 64'(core_reset), 64'd1);
            end else begin
                if (core_reset) crst++;
                if (s_valid && s_ready) begin
                    if (pos < msg_len) pos++;
                    else junk_bad++;
                end
                if (hold_st == 1 && core_in_ready) begin
                    hold_word = core_in;
                    hold_cnt  = 1;
                    hold_st   = 2;
                end else if (hold_st == 2) begin
                    if (core_buffer_full) begin
                        check({name, "_hold_core_in"}, 64'(core_in), 64'(hold_word));
                        check({name, "_hold_s_ready"}, 64'(s_ready), 64'd0);
                        hold_cnt++;
                    end else begin
                        hold_st = 0;
                    end
                end
                if (core_in_ready && !core_buffer_full) begin
                    got_q.push_back({core_in, core_is_last, core_byte_num});
                    if (core_is_last) dly = int'($urandom_range(0, 4));
                end
                if (m_valid && m_ready) begin
                    check({name, "_digest"}, 64'(m_data), 64'(dig[rx % 64]));
                    check({name, "_mlast"}, 64'(m_last), 64'(rx == NB - 1));
                    rx++;
                    if (m_last || rx >= NB + 4) done = 1'b1;
                end
            end

            @(posedge clk);
            #1;
            if (aborted && reset) begin
                reset   = 1'b0;
                s_valid = 1'b0;
                check({name, "_abort_mvalid"}, 64'(m_valid), 64'd0);
                check({name, "_abort_busy"}, 64'(busy), 64'd0);
                done = 1'b1;
            end
            cyc++;
        end

        if (!done) check({name, "_timeout"}, 64'd1, 64'd0);
        check({name, "_core_reset_cycles"}, 64'(crst), 64'(CLR_CYCLES));
        check({name, "_xfer_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({name, "_xfer"}, 64'(got_q[i]), 64'(exp_q[i]));
        check({name, "_junk_accepted"}, 64'(junk_bad), 64'd0);
        if (aborted) begin
            check({name, "_abort_rx"}, 64'(rx), 64'd5);
            idle_cycles(0);
            for (int i = 0; i < 6; i++) begin
                #1;
                check({name, "_post_abort_quiet"}, 64'({m_valid, core_in_ready, busy}), 64'd0);
                @(posedge clk);
                #1;
            end
        end else begin
            check({name, "_digest_len"}, 64'(rx), 64'(NB));
        end
        s_valid = 1'b0;
    endtask

    task automatic random_msg(input int len);
        msg_len = len;
        for (int i = 0; i < len; i++) msg[i] = 8'($urandom);
    endtask

    initial begin
        reset            = 1'b1;
        s_data           = '0;
        s_valid          = 1'b0;
        s_last           = 1'b0;
        m_ready          = 1'b0;
        core_buffer_full = 1'b0;
        core_out         = '0;
        core_out_ready   = 1'b0;
        set_modes(0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_core_reset", 64'(core_reset), 64'd1);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_core_in_ready", 64'(core_in_ready), 64'd0);
        check("rst_core_is_last", 64'(core_is_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_core_in", 64'(core_in), 64'd0);
        check("rst_byte_num", 64'(core_byte_num), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_core_reset", 64'(core_reset), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);

        // "abc"
        msg_len = 3; msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        run_message("abc");
        if (got_q.size() > 0) check("abc_word", 64'(got_q[0]), 64'({32'h61626300, 1'b1, 2'd3}));
        idle_cycles(3);

        // "abcd"
        msg_len = 4; msg[3] = 8'h64;
        run_message("abcd");
        if (got_q.size() > 1) begin
            check("abcd_word0", 64'(got_q[0]), 64'({32'h61626364, 1'b0, 2'd0}));
            check("abcd_word1", 64'(got_q[1]), 64'({32'h00000000, 1'b1, 2'd0}));
        end
        idle_cycles(2);

        // core full held for 10 cycles in PUSH
        set_modes(1, 0, 0, 0, 0);
        random_msg(6);
        run_message("hold");
        idle_cycles(2);

        // counting digest, m_ready toggling every cycle
        set_modes(0, 1, 1, 0, 0);
        random_msg(5);
        run_message("count_digest");
        idle_cycles(2);

        // reset while sending digest byte 5, then a fresh message
        set_modes(0, 0, 0, 1, 20);
        random_msg(7);
        run_message("abort");
        set_modes(0, 0, 0, 0, 20);
        random_msg(3);
        run_message("after_abort");

        // back-to-back 9-byte messages
        set_modes(0, 0, 0, 0, 25);
        random_msg(9);
        run_message("b2b_0");
        random_msg(9);
        run_message("b2b_1");
        idle_cycles(2);

        // randomized messages
        for (int k = 0; k < 8; k++) begin
            set_modes(0, 0, 0, 0, 30);
            random_msg(int'($urandom_range(1, 20)));
            run_message("rand");
            idle_cycles(int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
